// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      PAUSED = 2'd1,
      ADJUST = 2'd2
   } sw_state_e;

   typedef logic [3:0] bcd_t;

   localparam int SEC_MAX_DEF = 59;
   localparam int MIN_MAX_DEF = 59;

   function automatic sw_state_e flip_resume(input sw_state_e s);
      return (s == RUN) ? PAUSED : RUN;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Control/display bundle between stopwatch_ctrl and its neighbours.
interface stopwatch_ctrl_if;
   import stopwatch_pkg::*;

   logic one_hz_en;
   logic two_hz_en;
   logic pause_pulse;
   logic adj;
   logic select;
   bcd_t sec0;
   bcd_t sec1;
   bcd_t min0;
   bcd_t min1;
   logic blink;
   logic adj_out;
   logic select_out;
   logic running;

   modport master (
      output one_hz_en, two_hz_en, pause_pulse, adj, select,
      input  sec0, sec1, min0, min1, blink, adj_out, select_out, running
   );

   modport slave (
      input  one_hz_en, two_hz_en, pause_pulse, adj, select,
      output sec0, sec1, min0, min1, blink, adj_out, select_out, running
   );

endinterface

// File: rtl/stopwatch_ctrl_bcd_mod_counter.sv
// Two-digit BCD counter that wraps MAX -> 0; wrap flags the carry-out.
module bcd_mod_counter
   import stopwatch_pkg::*;
#(
   parameter int MAX = 59
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   output bcd_t units,
   output bcd_t tens,
   output logic wrap
);

   localparam bcd_t MAX_U = bcd_t'(MAX % 10);
   localparam bcd_t MAX_T = bcd_t'(MAX / 10);

   bcd_t r_units;
   bcd_t r_tens;
   logic w_at_max;

   assign w_at_max = (r_units == MAX_U) && (r_tens == MAX_T);
   assign wrap     = inc & w_at_max;
   assign units    = r_units;
   assign tens     = r_tens;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_units <= '0;
         r_tens  <= '0;
      end else if (inc) begin
         if (w_at_max) begin
            r_units <= '0;
            r_tens  <= '0;
         end else if (r_units == 4'd9) begin
            r_units <= '0;
            r_tens  <= r_tens + 4'd1;
         end else begin
            r_units <= r_units + 4'd1;
         end
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode FSM, MM:SS counters, blink phase and display controls.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int SEC_MAX = SEC_MAX_DEF,
   parameter int MIN_MAX = MIN_MAX_DEF
) (
   input  logic             clk,
   input  logic             rst,
   stopwatch_ctrl_if.slave  bus
);

   sw_state_e r_state;
   sw_state_e r_resume;
   sw_state_e w_next_state;
   sw_state_e w_next_resume;
   sw_state_e w_tog;
   logic      r_blink;
   logic      r_adj;
   logic      r_select;
   logic      w_run;
   logic      w_adjust;
   logic      w_sec_inc;
   logic      w_min_inc;
   logic      w_sec_wrap;
   logic      w_min_wrap;
   bcd_t      w_sec0;
   bcd_t      w_sec1;
   bcd_t      w_min0;
   bcd_t      w_min1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= RUN;
         r_resume <= RUN;
         r_blink  <= 1'b1;
         r_adj    <= 1'b0;
         r_select <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_resume <= w_next_resume;
         r_blink  <= r_blink ^ bus.two_hz_en;
         r_adj    <= bus.adj;
         r_select <= bus.select;
      end
   end

   always_comb begin
      w_next_state  = r_state;
      w_next_resume = r_resume;
      w_tog         = r_resume;
      unique case (r_state)
         RUN, PAUSED: begin
            // pause in the entry cycle lands in the resume target
            w_tog = bus.pause_pulse ? flip_resume(r_state) : r_state;
            if (bus.adj) begin
               w_next_state  = ADJUST;
               w_next_resume = w_tog;
            end else begin
               w_next_state  = w_tog;
            end
         end
         ADJUST: begin
            w_tog = bus.pause_pulse ? flip_resume(r_resume) : r_resume;
            w_next_resume = w_tog;
            if (!bus.adj) w_next_state = w_tog;
         end
         default: begin
            w_next_state  = RUN;
            w_next_resume = RUN;
         end
      endcase
   end

   assign w_run     = (r_state == RUN);
   assign w_adjust  = (r_state == ADJUST);
   assign w_sec_inc = (w_run & bus.one_hz_en)
                    | (w_adjust & bus.two_hz_en & r_select);
   assign w_min_inc = (w_run & w_sec_wrap)
                    | (w_adjust & bus.two_hz_en & ~r_select);

   bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_sec_inc),
      .units (w_sec0),
      .tens  (w_sec1),
      .wrap  (w_sec_wrap)
   );

   bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_min_inc),
      .units (w_min0),
      .tens  (w_min1),
      .wrap  (w_min_wrap)
   );

   assign bus.sec0       = w_sec0;
   assign bus.sec1       = w_sec1;
   assign bus.min0       = w_min0;
   assign bus.min1       = w_min1;
   assign bus.blink      = r_blink;
   assign bus.adj_out    = r_adj;
   assign bus.select_out = r_select;
   assign bus.running    = w_run;

   logic w_unused;
   assign w_unused = w_min_wrap;

endmodule
